// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB3 register-file completer:
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - APB_ID_CODE             : default upper half of the read-only status word
//   - apb_slv_state_t         : completer FSM states
//   - sat_inc8()              : saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int          APB_ADDR_W  = 32;
    localparam int          APB_DATA_W  = 32;
    localparam logic [15:0] APB_ID_CODE = 16'hA5B3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_t;

    // Counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// -----------------------------------------------------------------------------
// apb_regbank
// Register storage for the APB completer.
//   PCLK, PRESETn : clock / synchronous active-low reset
//   we, widx,     : write strobe, word index and data (committed at PCLK edge)
//   wdata
//   ridx          : read word index (combinational read mux -> rdata)
//   err_cnt       : current error count, folded into the status word
//   rdata         : selected word
//   ctrl_out      : live value of register 0
// The last index holds no storage: it is the read-only status word
// {ID_CODE, err_cnt, NUM_REGS[7:0]}. Writes to it are filtered upstream.
// -----------------------------------------------------------------------------
module apb_regbank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter int          DATA_WIDTH = APB_DATA_W,
    parameter logic [15:0] ID_CODE    = APB_ID_CODE,
    localparam int         IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    input  logic [7:0]            err_cnt,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ctrl_out
);

    logic [DATA_WIDTH-1:0] words [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
        if (gi == NUM_REGS - 1) begin : g_ro
            assign words[gi] = DATA_WIDTH'({ID_CODE, err_cnt, 8'(NUM_REGS)});
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] word_q;
            logic [DATA_WIDTH-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we && (widx == IDX_W'(gi))) begin
                    word_d = wdata;
                end
            end

            always_ff @(posedge PCLK) begin
                if (!PRESETn) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign words[gi] = word_q;
        end
    end

    assign rdata    = words[ridx];
    assign ctrl_out = words[0];

endmodule

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB3 completer in front of a bank of NUM_REGS 32-bit registers.
//   PCLK, PRESETn        : clock / synchronous active-low reset
//   PSELx, PENABLE,      : APB request (select, access phase, direction)
//   PWRITE
//   PADDR, PWDATA        : byte address / write data, latched in the setup cycle
//   wait_cfg             : wait states for this transfer, latched in the setup cycle
//   PREADY, PRDATA,      : registered response; PRDATA/PSLVERR only meaningful
//   PSLVERR                with PREADY
//   ctrl_out             : live register 0
//   err_cnt              : saturating count of completed error responses
// The response (PREADY/PSLVERR/PRDATA) is computed on the edge that enters READY,
// so read data is the register value at that moment and the outputs are flops.
// -----------------------------------------------------------------------------
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          ADDR_WIDTH = APB_ADDR_W,
    parameter int          DATA_WIDTH = APB_DATA_W,
    parameter int          NUM_REGS   = 16,
    parameter logic [15:0] ID_CODE    = APB_ID_CODE
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            wait_cfg,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic [7:0]            err_cnt
);

    localparam int IDX_W = $clog2(NUM_REGS);

    apb_slv_state_t        state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  write_q,   write_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  pready_q,  pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  setup;
    logic                  enter_ready;
    logic                  reg_we;
    logic                  dec_err;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    // Transfer fields are captured only on a setup cycle seen from IDLE; later
    // changes to PADDR/PWDATA are ignored for the rest of the transfer.
    always_comb begin
        setup   = (state_q == IDLE) && PSELx && !PENABLE;
        addr_d  = setup ? PADDR  : addr_q;
        write_d = setup ? PWRITE : write_q;
        wdata_d = setup ? PWDATA : wdata_q;
    end

    // Decode on the value being latched so a zero-wait transfer can respond
    // in the first access cycle.
    assign rd_idx  = addr_d[IDX_W+1:2];
    assign wr_idx  = addr_q[IDX_W+1:2];
    assign dec_err = (addr_d[1:0] != 2'b00)
                  || (addr_d >= ADDR_WIDTH'(4 * NUM_REGS))
                  || (write_d && (rd_idx == IDX_W'(NUM_REGS - 1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_cnt_d   = err_cnt_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
        reg_we      = 1'b0;
        enter_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    cnt_d = wait_cfg;
                    if (wait_cfg == 4'd0) begin
                        enter_ready = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSELx) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        enter_ready = 1'b1;
                    end
                end
            end
            READY: begin
                state_d = IDLE;
                // Without PSELx & PENABLE here the transfer is abandoned silently.
                if (PSELx && PENABLE) begin
                    if (pslverr_q) begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end else if (write_q) begin
                        reg_we = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_ready) begin
            state_d   = READY;
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = (dec_err || write_d) ? '0 : rd_data;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    apb_regbank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_CODE    (ID_CODE)
    ) u_regbank (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .we       (reg_we),
        .widx     (wr_idx),
        .wdata    (wdata_q),
        .ridx     (rd_idx),
        .err_cnt  (err_cnt_q),
        .rdata    (rd_data),
        .ctrl_out (ctrl_out)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Drives APB transfers into apb_slave_regfile. Expected responses (data, error,
// access-cycle latency) are pushed to sb_q when a transfer is issued; observed
// responses are pushed to obs_q when PREADY is seen, and each scenario task
// pairs them up and compares.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

    localparam int BUDGET = 32;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  wait_cfg;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [31:0] ctrl_out;
    logic [7:0]  err_cnt;

    always #5 PCLK = ~PCLK;

    apb_slave_regfile dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .wait_cfg (wait_cfg),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .ctrl_out (ctrl_out),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } obs_t;

    exp_t       sb_q[$];
    obs_t       obs_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_err_cnt;

    function automatic logic [7:0] next_cnt(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] status_word(input logic [7:0] cnt);
        return {16'hA5B3, cnt, 8'h10};
    endfunction

    task automatic expect_xfer(input string name, input logic [31:0] rdata,
                               input logic err, input int lat);
        exp_t e;
        e.name  = name;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    // One transfer: setup cycle, then access cycles until PREADY (bounded).
    // Leaves PSELx/PENABLE high so the transfer completes on the next edge;
    // the caller either idles the bus or starts the next setup directly.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] wcfg);
        obs_t o;
        int   n;
        @(negedge PCLK);
        PSELx    = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = wr;
        PADDR    = addr;
        PWDATA   = data;
        wait_cfg = wcfg;
        @(negedge PCLK);
        PENABLE = 1'b1;
        // Disturb the bus after setup; the completer must use latched values.
        PADDR   = addr ^ 32'h4;
        PWDATA  = ~data;
        n = 1;
        while (PREADY !== 1'b1 && n < BUDGET) begin
            @(negedge PCLK);
            n++;
        end
        o.rdata = PRDATA;
        o.err   = PSLVERR;
        o.lat   = (PREADY === 1'b1) ? n : -1;
        obs_q.push_back(o);
    endtask

    task automatic bus_idle(input int cycles);
        repeat (cycles) begin
            @(negedge PCLK);
            PSELx   = 1'b0;
            PENABLE = 1'b0;
        end
    endtask

    task automatic test_reset();
        PRESETn  = 1'b0;
        PSELx    = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        wait_cfg = '0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        exp_err_cnt = 8'h00;
        compared++;
        if (PREADY !== 1'b0) begin mismatched++; $display("FAIL reset_pready: got %b want 0", PREADY); end
        compared++;
        if (PSLVERR !== 1'b0) begin mismatched++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
        compared++;
        if (PRDATA !== 32'h0) begin mismatched++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
        compared++;
        if (ctrl_out !== 32'h0) begin mismatched++; $display("FAIL reset_ctrl_out: got %h want 0", ctrl_out); end
        compared++;
        if (err_cnt !== 8'h0) begin mismatched++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
        $display("reset: outputs checked after release");
    endtask

    task automatic test_zero_wait();
        exp_t e;
        obs_t o;
        expect_xfer("zw_wr04", 32'h0, 1'b0, 1);
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'd0);
        expect_xfer("zw_rd04", 32'hDEADBEEF, 1'b0, 1);
        xfer(1'b0, 32'h04, 32'h0, 4'd0);
        bus_idle(1);
        compared++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            mismatched++;
            $display("FAIL zw_release: got pready=%b pslverr=%b prdata=%h want 0/0/0", PREADY, PSLVERR, PRDATA);
        end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        obs_t o;
        expect_xfer("ws_wr00", 32'h0, 1'b0, 4);
        xfer(1'b1, 32'h00, 32'h12345678, 4'd3);
        bus_idle(1);
        expect_xfer("ws_rd00", 32'h12345678, 1'b0, 4);
        xfer(1'b0, 32'h00, 32'h0, 4'd3);
        bus_idle(1);
        compared++;
        if (ctrl_out !== 32'h12345678) begin mismatched++; $display("FAIL ws_ctrl_out: got %h want 12345678", ctrl_out); end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_ro_status();
        exp_t e;
        obs_t o;
        expect_xfer("ro_wr3c", 32'h0, 1'b1, 1);
        xfer(1'b1, 32'h3C, 32'hFFFFFFFF, 4'd0);
        exp_err_cnt = next_cnt(exp_err_cnt);
        expect_xfer("ro_rd3c", status_word(exp_err_cnt), 1'b0, 2);
        xfer(1'b0, 32'h3C, 32'h0, 4'd1);
        bus_idle(1);
        compared++;
        if (err_cnt !== exp_err_cnt) begin mismatched++; $display("FAIL ro_err_cnt: got %h want %h", err_cnt, exp_err_cnt); end
        compared++;
        if (ctrl_out !== 32'h12345678) begin mismatched++; $display("FAIL ro_ctrl_kept: got %h want 12345678", ctrl_out); end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_addr_errors();
        exp_t e;
        obs_t o;
        expect_xfer("ae_rd41", 32'h0, 1'b1, 2);
        xfer(1'b0, 32'h41, 32'h0, 4'd1);
        exp_err_cnt = next_cnt(exp_err_cnt);
        expect_xfer("ae_rd40", 32'h0, 1'b1, 1);
        xfer(1'b0, 32'h40, 32'h0, 4'd0);
        exp_err_cnt = next_cnt(exp_err_cnt);
        expect_xfer("ae_wr38", 32'h0, 1'b0, 1);
        xfer(1'b1, 32'h38, 32'h0BADF00D, 4'd0);
        expect_xfer("ae_rd38", 32'h0BADF00D, 1'b0, 1);
        xfer(1'b0, 32'h38, 32'h0, 4'd0);
        bus_idle(1);
        compared++;
        if (err_cnt !== exp_err_cnt) begin mismatched++; $display("FAIL ae_err_cnt: got %h want %h", err_cnt, exp_err_cnt); end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        exp_t e;
        obs_t o;
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h08; PWDATA = 32'h55; wait_cfg = 4'd3;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        compared++;
        if (PREADY !== 1'b0) begin mismatched++; $display("FAIL rm_wait_pready: got %b want 0", PREADY); end
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1; PSELx = 1'b0; PENABLE = 1'b0;
        exp_err_cnt = 8'h00;
        @(negedge PCLK);
        compared++;
        if (PREADY !== 1'b0) begin mismatched++; $display("FAIL rm_pready: got %b want 0", PREADY); end
        compared++;
        if (err_cnt !== exp_err_cnt) begin mismatched++; $display("FAIL rm_err_cnt: got %h want %h", err_cnt, exp_err_cnt); end
        compared++;
        if (ctrl_out !== 32'h0) begin mismatched++; $display("FAIL rm_ctrl_out: got %h want 0", ctrl_out); end
        expect_xfer("rm_rd08", 32'h0, 1'b0, 1);
        xfer(1'b0, 32'h08, 32'h0, 4'd0);
        bus_idle(1);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        // Write to 0x10 abandoned in WAIT by dropping PSELx.
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h10; PWDATA = 32'h00000BAD; wait_cfg = 4'd3;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        compared++;
        if (PREADY !== 1'b0) begin mismatched++; $display("FAIL bb_abort_pready: got %b want 0", PREADY); end
        PSELx = 1'b0; PENABLE = 1'b0;
        expect_xfer("bb_wr0c", 32'h0, 1'b0, 1);
        xfer(1'b1, 32'h0C, 32'hCAFEF00D, 4'd0);
        expect_xfer("bb_rd0c", 32'hCAFEF00D, 1'b0, 1);
        xfer(1'b0, 32'h0C, 32'h0, 4'd0);
        expect_xfer("bb_rd10", 32'h0, 1'b0, 1);
        xfer(1'b0, 32'h10, 32'h0, 4'd0);
        bus_idle(1);
        compared++;
        if (err_cnt !== exp_err_cnt) begin mismatched++; $display("FAIL bb_err_cnt: got %h want %h", err_cnt, exp_err_cnt); end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_err_saturate();
        exp_t e;
        obs_t o;
        for (int i = 0; i < 270; i++) begin
            expect_xfer("sat_rd01", 32'h0, 1'b1, 1);
            xfer(1'b0, 32'h01, 32'h0, 4'd0);
            exp_err_cnt = next_cnt(exp_err_cnt);
        end
        expect_xfer("sat_rd3c", status_word(exp_err_cnt), 1'b0, 1);
        xfer(1'b0, 32'h3C, 32'h0, 4'd0);
        bus_idle(1);
        compared++;
        if (err_cnt !== exp_err_cnt) begin mismatched++; $display("FAIL sat_err_cnt: got %h want %h", err_cnt, exp_err_cnt); end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin mismatched++; $display("FAIL %s: got no response want one", e.name); continue; end
            o = obs_q.pop_front();
            $display("xfer %s: lat=%0d err=%b rdata=%h", e.name, o.lat, o.err, o.rdata);
            if (o.lat !== e.lat) begin mismatched++; $display("FAIL %s_lat: got %0d want %0d", e.name, o.lat, e.lat); end
            compared++;
            if (o.err !== e.err) begin mismatched++; $display("FAIL %s_err: got %b want %b", e.name, o.err, e.err); end
            compared++;
            if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL %s_rdata: got %h want %h", e.name, o.rdata, e.rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_ro_status();
        test_addr_errors();
        test_reset_mid_transfer();
        test_back_to_back();
        test_err_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
